// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan bus receiver: qualifies stable digits,
// decodes them to BCD and assembles frames for a valid/ready sink.
module seg7_scan_decoder #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   frame_data,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYC);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_FULL    = 1'b1;

  logic [6:0]          r_seg_q;
  logic [DIGITS-1:0]   r_an_q;
  logic [6:0]          r_seg_p;
  logic [DIGITS-1:0]   r_an_p;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_slot_data;
  logic [DIGITS-1:0]   r_slot_err;
  logic [DIGITS-1:0]   r_got;
  logic [0:0]          r_state;
  logic [4*DIGITS-1:0] r_frame_data;
  logic [DIGITS-1:0]   r_frame_err;

  logic                w_onehot;
  logic                w_same;
  logic [CW-1:0]       w_cnt;
  logic                w_cap;
  logic [3:0]          w_dec_val;
  logic                w_dec_err;
  logic [4*DIGITS-1:0] w_slot_data_n;
  logic [DIGITS-1:0]   w_slot_err_n;
  logic [DIGITS-1:0]   w_got_n;
  logic                w_complete;
  logic                w_load;

  function automatic logic [4:0] f_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      default:    r = 5'h1F;
    endcase
    return r;
  endfunction

  assign w_onehot = (r_an_q != '0) &&
                    ((r_an_q & (r_an_q - DIGITS'(1))) == '0);
  assign w_same   = (r_seg_q == r_seg_p) && (r_an_q == r_an_p);
  assign {w_dec_err, w_dec_val} = f_decode(r_seg_q);

  // Run length of the current sample; blanking holds it at zero.
  always_comb begin
    w_cnt = '0;
    if (!w_onehot)
      w_cnt = '0;
    else if (w_same)
      w_cnt = (r_cnt == CMAX) ? CMAX : r_cnt + CW'(1);
    else
      w_cnt = CW'(1);
  end

  // One capture per dwell: only when the count reaches the limit.
  assign w_cap = w_onehot && (w_cnt == CMAX) &&
                 !(w_same && (r_cnt == CMAX));

  // Next slot contents and collected-digit mask after a capture.
  always_comb begin
    w_slot_data_n = r_slot_data;
    w_slot_err_n  = r_slot_err;
    w_got_n       = r_got;
    if (w_cap) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (r_an_q[i]) begin
          w_slot_data_n[4*i +: 4] = w_dec_val;
          w_slot_err_n[i]         = w_dec_err;
          w_got_n[i]              = 1'b1;
        end
      end
    end
  end

  assign w_complete = w_cap && (&w_got_n);
  assign w_load     = w_complete &&
                      ((r_state == ST_COLLECT) || frame_ready);

  // Register the bus and keep the previous sample for comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_q <= '0;
      r_an_q  <= '0;
      r_seg_p <= '0;
      r_an_p  <= '0;
    end else begin
      r_seg_q <= seg;
      r_an_q  <= an;
      r_seg_p <= r_seg_q;
      r_an_p  <= r_an_q;
    end
  end

  // Stability counter.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else
      r_cnt <= w_cnt;
  end

  // Slot storage; a completed frame restarts collection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_data <= '0;
      r_slot_err  <= '0;
      r_got       <= '0;
    end else begin
      r_slot_data <= w_slot_data_n;
      r_slot_err  <= w_slot_err_n;
      r_got       <= w_complete ? '0 : w_got_n;
    end
  end

  // Output register and COLLECT/FULL handshake state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_COLLECT;
      r_frame_data <= '0;
      r_frame_err  <= '0;
    end else if (w_load) begin
      r_state      <= ST_FULL;
      r_frame_data <= w_slot_data_n;
      r_frame_err  <= w_slot_err_n;
    end else if ((r_state == ST_FULL) && frame_ready) begin
      r_state      <= ST_COLLECT;
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_err   = r_frame_err;
  assign frame_valid = (r_state == ST_FULL);
  assign overrun     = !rst && w_complete &&
                       (r_state == ST_FULL) && !frame_ready;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed digit sequences,
// expected frames queued and checked by a separate monitor.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = '0;
  logic [3:0]  an  = '0;
  logic        frame_ready = 1'b1;
  logic [15:0] frame_data;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        overrun;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  e;
  } frm_t;

  frm_t sbq[$];
  frm_t m_exp;
  int n_chk   = 0;
  int n_err   = 0;
  int n_valid = 0;
  int n_ovr   = 0;
  int v0;
  int o0;

  seg7_scan_decoder #(
    .DIGITS(4),
    .STABLE_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seg(seg),
    .an(an),
    .frame_data(frame_data),
    .frame_err(frame_err),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] sg(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a,
                       input logic [6:0] s,
                       input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] e);
    sbq.push_back('{d: d, e: e});
  endtask

  // Hold a completing digit exactly 4 cycles; frame must appear at t+5.
  task automatic hold_exact(input logic [3:0] a, input logic [6:0] s);
    an  = a;
    seg = s;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("early_valid", frame_valid, 0);
      @(posedge clk);
      #1;
    end
    an  = '0;
    seg = '0;
    @(negedge clk);
    check("early_valid_t4", frame_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("valid_at_t5", frame_valid, 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop the expected frame on every accepted handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) n_valid++;
      if (overrun)     n_ovr++;
      if (frame_valid && frame_ready) begin
        n_chk++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL frame_unexpected: got data %h err %b, expected none",
                   frame_data, frame_err);
        end else begin
          m_exp = sbq.pop_front();
          if ({frame_data, frame_err} !== {m_exp.d, m_exp.e}) begin
            n_err++;
            $display("FAIL frame: got data %h err %b expected data %h err %b",
                     frame_data, frame_err, m_exp.d, m_exp.e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", frame_valid, 0);
    check("rst_data", frame_data, 0);
    check("rst_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic frame 4321
    v0 = n_valid;
    push(16'h4321, 4'b0000);
    drive(4'b0001, sg(1), 6);
    drive(4'b0010, sg(2), 6);
    drive(4'b0100, sg(3), 6);
    drive(4'b1000, sg(4), 6);
    drive(4'b0000, 7'd0, 4);
    check("t1_pulses", n_valid - v0, 1);

    // short dwell does not capture; exact dwell captures on time
    v0 = n_valid;
    drive(4'b0001, sg(1), 3);
    drive(4'b0000, 7'd0, 2);
    drive(4'b0010, sg(5), 6);
    drive(4'b0100, sg(6), 6);
    drive(4'b1000, sg(7), 6);
    drive(4'b0000, 7'd0, 3);
    check("t2_no_capture", n_valid - v0, 0);
    push(16'h7651, 4'b0000);
    hold_exact(4'b0001, sg(1));
    drive(4'b0000, 7'd0, 2);

    // illegal pattern in slot 2
    push(16'h8F09, 4'b0100);
    drive(4'b0001, sg(9), 6);
    drive(4'b0010, sg(0), 6);
    drive(4'b0100, 7'b1000000, 6);
    drive(4'b1000, sg(8), 6);
    drive(4'b0000, 7'd0, 3);

    // blanking and mid-dwell change
    v0 = n_valid;
    drive(4'b0011, sg(1), 2);
    drive(4'b0011, sg(2), 2);
    drive(4'b0000, sg(3), 3);
    drive(4'b0011, sg(5), 6);
    drive(4'b0010, sg(7), 6);
    drive(4'b0100, sg(3), 6);
    drive(4'b1000, sg(4), 6);
    drive(4'b0000, 7'd0, 2);
    check("t5_blank_no_capture", n_valid - v0, 0);
    push(16'h4376, 4'b0000);
    drive(4'b0001, sg(5), 2);
    hold_exact(4'b0001, sg(6));
    drive(4'b0000, 7'd0, 2);

    // backpressure and overrun
    frame_ready = 1'b0;
    o0 = n_ovr;
    push(16'h8765, 4'b0000);
    drive(4'b0001, sg(5), 6);
    drive(4'b0010, sg(6), 6);
    drive(4'b0100, sg(7), 6);
    drive(4'b1000, sg(8), 6);
    drive(4'b0000, 7'd0, 2);
    check("t4_valid_held", frame_valid, 1);
    drive(4'b0001, sg(1), 6);
    drive(4'b0010, sg(1), 6);
    drive(4'b0100, sg(1), 6);
    drive(4'b1000, sg(1), 6);
    drive(4'b0000, 7'd0, 2);
    check("t4_overrun_pulses", n_ovr - o0, 1);
    check("t4_data_held", frame_data, 16'h8765);
    check("t4_valid_still", frame_valid, 1);
    frame_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t4_valid_drop", frame_valid, 0);
    @(posedge clk);
    #1;

    // reset with pending frame and partial collection
    frame_ready = 1'b0;
    drive(4'b0001, sg(2), 6);
    drive(4'b0010, sg(2), 6);
    drive(4'b0100, sg(2), 6);
    drive(4'b1000, sg(2), 6);
    drive(4'b0001, sg(3), 6);
    drive(4'b0010, sg(3), 6);
    drive(4'b0100, sg(3), 6);
    check("t6_pending", frame_valid, 1);
    rst = 1'b1;
    an  = '0;
    seg = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_rst_valid", frame_valid, 0);
    check("t6_rst_data", frame_data, 0);
    check("t6_rst_err", frame_err, 0);
    frame_ready = 1'b1;
    v0 = n_valid;
    drive(4'b1000, sg(9), 6);
    drive(4'b0000, 7'd0, 3);
    check("t6_got_cleared", n_valid - v0, 0);
    push(16'h9111, 4'b0000);
    drive(4'b0001, sg(1), 6);
    drive(4'b0010, sg(1), 6);
    drive(4'b0100, sg(1), 6);
    drive(4'b0000, 7'd0, 3);

    check("queue_empty", sbq.size(), 0);
    check("total_overrun", n_ovr, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
